// File: rtl/instr_fetch_unit_pkg.sv
// Shared CPU constants and types for the fetch stage.
// Holds the fetch FSM encoding, the datapath word width and the default fetch timeout.
package instr_fetch_unit_pkg;

    localparam int XLEN               = 32;
    localparam int DEF_TIMEOUT_CYCLES = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_timeout_ctr.sv
// Memory-request timeout counter (module fetch_timeout_ctr).
// Only built when FETCH_TIMEOUT_EN is defined; the default build has no counter at all.
`ifdef FETCH_TIMEOUT_EN
module fetch_timeout_ctr #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(LIMIT) + 1;

    logic [W-1:0] count_r;

    // Count enabled cycles; clear has priority so every request starts from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {W{1'b0}};
        end else if (clear) begin
            count_r <= {W{1'b0}};
        end else if (enable) begin
            count_r <= count_r + W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = enable && (count_r == W'(LIMIT - 1));

endmodule
`endif

// File: rtl/instr_fetch_unit.sv
// Fetch stage: latches the PC, reads instruction memory via req/ack and holds the word for decode.
// Optional FETCH_TIMEOUT_EN adds a sticky fetch_err when memory never acknowledges.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
`ifdef FETCH_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
)
`endif
(
    input  logic            clk,
    input  logic            startin,
    input  logic [XLEN-1:0] pc_addr,
    input  logic            fetch_en,
    input  logic            flush,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ack,
    output logic [XLEN-1:0] instr_out,
    output logic [XLEN-1:0] instr_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic            pc_advance,
    output logic            fetch_err
);

    fetch_state_e    state_r, state_n;
    logic [XLEN-1:0] addr_r, addr_n;
    logic [XLEN-1:0] instr_r, instr_n;
    logic [XLEN-1:0] ipc_r, ipc_n;
    logic            req_r, req_n;
    logic            valid_r, valid_n;
    logic            adv_r, adv_n;
    logic            discard_r, discard_n;
    logic            timeout_s;
    logic            err_s;
    logic [XLEN-1:0] aligned_pc_s;
    logic            unused_pc_lsb_s;

    assign aligned_pc_s    = {pc_addr[XLEN-1:2], 2'b00};
    assign unused_pc_lsb_s = ^pc_addr[1:0];

`ifdef FETCH_TIMEOUT_EN
    logic err_r, err_n;

    fetch_timeout_ctr #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk     (clk),
        .rst     (startin),
        .clear   (state_r != ST_REQ),
        .enable  (state_r == ST_REQ),
        .expired (timeout_s)
    );

    // Sticky error flag; only a reset clears it.
    always_ff @(posedge clk or posedge startin) begin
        if (startin) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_n;
        end
    end

    assign err_s = err_r;
`else
    assign timeout_s = 1'b0;
    assign err_s     = 1'b0;
`endif

    // Next-state and next-output logic for the fetch FSM.
    always_comb begin
        state_n   = state_r;
        addr_n    = addr_r;
        instr_n   = instr_r;
        ipc_n     = ipc_r;
        req_n     = req_r;
        valid_n   = valid_r;
        adv_n     = 1'b0;
        discard_n = discard_r;
`ifdef FETCH_TIMEOUT_EN
        err_n     = err_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (fetch_en && !err_s) begin
                    addr_n  = aligned_pc_s;
                    req_n   = 1'b1;
                    state_n = ST_REQ;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    req_n     = 1'b0;
                    discard_n = 1'b0;
                    // A flush seen at any point of the request (including the ack cycle) drops the word.
                    if (discard_r || flush) begin
                        state_n = ST_IDLE;
                    end else begin
                        instr_n = mem_rdata;
                        ipc_n   = addr_r;
                        valid_n = 1'b1;
                        adv_n   = 1'b1;
                        state_n = ST_HOLD;
                    end
                end else if (timeout_s) begin
                    req_n     = 1'b0;
                    discard_n = 1'b0;
                    state_n   = ST_IDLE;
`ifdef FETCH_TIMEOUT_EN
                    err_n     = 1'b1;
`endif
                end else if (flush) begin
                    discard_n = 1'b1;
                end else begin
                    state_n = ST_REQ;
                end
            end
            ST_HOLD: begin
                if (flush) begin
                    valid_n = 1'b0;
                    state_n = ST_IDLE;
                end else if (instr_ready) begin
                    valid_n = 1'b0;
                    if (fetch_en) begin
                        addr_n  = aligned_pc_s;
                        req_n   = 1'b1;
                        state_n = ST_REQ;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else begin
                    state_n = ST_HOLD;
                end
            end
            default: begin
                state_n   = ST_IDLE;
                req_n     = 1'b0;
                valid_n   = 1'b0;
                discard_n = 1'b0;
            end
        endcase
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or posedge startin) begin
        if (startin) begin
            state_r   <= ST_IDLE;
            addr_r    <= {XLEN{1'b0}};
            instr_r   <= {XLEN{1'b0}};
            ipc_r     <= {XLEN{1'b0}};
            req_r     <= 1'b0;
            valid_r   <= 1'b0;
            adv_r     <= 1'b0;
            discard_r <= 1'b0;
        end else begin
            state_r   <= state_n;
            addr_r    <= addr_n;
            instr_r   <= instr_n;
            ipc_r     <= ipc_n;
            req_r     <= req_n;
            valid_r   <= valid_n;
            adv_r     <= adv_n;
            discard_r <= discard_n;
        end
    end

    assign mem_req     = req_r;
    assign mem_addr    = addr_r;
    assign instr_out   = instr_r;
    assign instr_pc    = ipc_r;
    assign instr_valid = valid_r;
    assign pc_advance  = adv_r;
    assign fetch_err   = err_s;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed test-plan steps then randomized transactions.
// Expected values come from the fetch rules (aligned address, delivery count); FETCH_TIMEOUT_EN selects the timeout section.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        startin;
    logic [31:0] pc_addr;
    logic        fetch_en;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        pc_advance;
    logic        fetch_err;

    int n_pass   = 0;
    int n_total  = 0;
    int n_fail   = 0;
    int adv_seen = 0;
    int adv_exp  = 0;

    instr_fetch_unit dut (
        .clk         (clk),
        .startin     (startin),
        .pc_addr     (pc_addr),
        .fetch_en    (fetch_en),
        .flush       (flush),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .instr_out   (instr_out),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc_advance  (pc_advance),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pc_advance === 1'b1) adv_seen++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Start a fetch from IDLE; fetch_en is then dropped, which must not abort the request.
    task automatic issue(input logic [31:0] pc);
        pc_addr  = pc;
        fetch_en = 1'b1;
        cyc();
        fetch_en = 1'b0;
        pc_addr  = $urandom;
        chk("req_high", {31'd0, mem_req}, 32'd1);
        chk("req_addr", mem_addr, word_of(pc));
        chk("req_novalid", {31'd0, instr_valid}, 32'd0);
    endtask

    // Act as memory: wait states then ack; optional flush on the first wait cycle.
    task automatic serve(input logic [31:0] addr, input int waits, input logic [31:0] data,
                         input bit flush_req, output bit delivered);
        for (int i = 0; i < waits; i++) begin
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            flush     = flush_req && (i == 0);
            cyc();
            flush = 1'b0;
            chk("wait_req", {31'd0, mem_req}, 32'd1);
            chk("wait_addr", mem_addr, addr);
            chk("wait_novalid", {31'd0, instr_valid}, 32'd0);
        end
        mem_ack   = 1'b1;
        mem_rdata = data;
        cyc();
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        delivered = !flush_req;
        chk("ack_valid", {31'd0, instr_valid}, {31'd0, delivered});
        chk("ack_adv", {31'd0, pc_advance}, {31'd0, delivered});
        chk("ack_req_low", {31'd0, mem_req}, 32'd0);
        if (delivered) begin
            adv_exp++;
            chk("ack_instr", instr_out, data);
            chk("ack_ipc", instr_pc, addr);
        end
    endtask

    // Hold the word for 'delay' cycles (stray acks ignored), then accept or flush.
    task automatic hold(input logic [31:0] data, input logic [31:0] addr, input int delay,
                        input bit do_flush, input bit next_en, input logic [31:0] next_pc);
        for (int i = 0; i < delay; i++) begin
            instr_ready = 1'b0;
            mem_ack     = 1'($urandom_range(0, 1));
            mem_rdata   = $urandom;
            cyc();
            chk("hold_valid", {31'd0, instr_valid}, 32'd1);
            chk("hold_instr", instr_out, data);
            chk("hold_ipc", instr_pc, addr);
            chk("hold_adv", {31'd0, pc_advance}, 32'd0);
            chk("hold_req", {31'd0, mem_req}, 32'd0);
        end
        mem_ack     = 1'b0;
        instr_ready = do_flush ? 1'($urandom_range(0, 1)) : 1'b1;
        flush       = do_flush;
        fetch_en    = next_en;
        pc_addr     = next_pc;
        cyc();
        instr_ready = 1'b0;
        flush       = 1'b0;
        fetch_en    = 1'b0;
        pc_addr     = $urandom;
        chk("rel_valid", {31'd0, instr_valid}, 32'd0);
        chk("rel_adv", {31'd0, pc_advance}, 32'd0);
        if (next_en && !do_flush) begin
            chk("b2b_req", {31'd0, mem_req}, 32'd1);
            chk("b2b_addr", mem_addr, word_of(next_pc));
        end else begin
            chk("rel_req", {31'd0, mem_req}, 32'd0);
        end
    endtask

    initial begin
        bit          got;
        bit          in_req;
        bit          hf;
        bit          ne;
        int          waits;
        logic [31:0] pc;
        logic [31:0] data;
        logic [31:0] np;

        startin     = 1'b1;
        pc_addr     = 32'd0;
        fetch_en    = 1'b0;
        flush       = 1'b0;
        mem_rdata   = 32'd0;
        mem_ack     = 1'b0;
        instr_ready = 1'b0;
        cyc();
        cyc();
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_adv", {31'd0, pc_advance}, 32'd0);
        chk("rst_err", {31'd0, fetch_err}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_instr", instr_out, 32'd0);
        chk("rst_ipc", instr_pc, 32'd0);
        startin = 1'b0;
        cyc();

        // Zero-wait fetch.
        issue(32'h0000_0040);
        serve(32'h0000_0040, 0, 32'h8C22_0004, 1'b0, got);
        hold(32'h8C22_0004, 32'h0000_0040, 1, 1'b0, 1'b0, 32'd0);

        // Wait states, decode stall, then back-to-back fetch of 0x44.
        issue(32'h0000_0100);
        serve(32'h0000_0100, 3, 32'h1234_5678, 1'b0, got);
        hold(32'h1234_5678, 32'h0000_0100, 4, 1'b0, 1'b1, 32'h0000_0044);
        serve(32'h0000_0044, 0, 32'hCAFE_0044, 1'b0, got);
        hold(32'hCAFE_0044, 32'h0000_0044, 0, 1'b0, 1'b0, 32'd0);

        // Flush during a 2-cycle wait, then flush in HOLD (with fetch_en asserted).
        issue(32'h0000_0200);
        serve(32'h0000_0200, 2, 32'hDEAD_BEEF, 1'b1, got);
        issue(32'h0000_0204);
        serve(32'h0000_0204, 0, 32'hA5A5_5A5A, 1'b0, got);
        hold(32'hA5A5_5A5A, 32'h0000_0204, 1, 1'b1, 1'b1, 32'h0000_0208);

        // Misaligned PC.
        issue(32'h0000_0047);
        serve(32'h0000_0044, 1, 32'h0BAD_F00D, 1'b0, got);
        hold(32'h0BAD_F00D, 32'h0000_0044, 0, 1'b0, 1'b0, 32'd0);

        // Asynchronous reset between edges while in REQ.
        issue(32'h0000_0300);
        #2 startin = 1'b1;
        #1;
        chk("arst_req", {31'd0, mem_req}, 32'd0);
        chk("arst_valid", {31'd0, instr_valid}, 32'd0);
        chk("arst_err", {31'd0, fetch_err}, 32'd0);
        chk("arst_addr", mem_addr, 32'd0);
        cyc();
        startin = 1'b0;
        issue(32'h0000_0304);
        serve(32'h0000_0304, 1, 32'h5555_AAAA, 1'b0, got);
        hold(32'h5555_AAAA, 32'h0000_0304, 2, 1'b0, 1'b0, 32'd0);

`ifdef FETCH_TIMEOUT_EN
        // No ack: 16 REQ cycles then sticky error, no further requests until reset.
        issue(32'h0000_0400);
        for (int i = 1; i < 16; i++) begin
            cyc();
            chk("to_req_wait", {31'd0, mem_req}, 32'd1);
            chk("to_err_wait", {31'd0, fetch_err}, 32'd0);
        end
        cyc();
        chk("to_req_drop", {31'd0, mem_req}, 32'd0);
        chk("to_err_set", {31'd0, fetch_err}, 32'd1);
        fetch_en = 1'b1;
        pc_addr  = 32'h0000_0500;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("to_blocked", {31'd0, mem_req}, 32'd0);
            chk("to_sticky", {31'd0, fetch_err}, 32'd1);
        end
        fetch_en = 1'b0;
        startin  = 1'b1;
        cyc();
        startin = 1'b0;
        chk("to_err_clr", {31'd0, fetch_err}, 32'd0);
        cyc();
`else
        // Without the timeout feature a long wait simply keeps the request up.
        issue(32'h0000_0400);
        serve(32'h0000_0400, 20, 32'h0F0F_0F0F, 1'b0, got);
        chk("nto_err", {31'd0, fetch_err}, 32'd0);
        hold(32'h0F0F_0F0F, 32'h0000_0400, 0, 1'b0, 1'b0, 32'd0);
`endif

        // Randomized transactions.
        in_req = 1'b0;
        np     = 32'd0;
        repeat (30) begin
            if (in_req) begin
                pc = np;
            end else begin
                pc = $urandom;
                issue(pc);
            end
            waits = $urandom_range(0, 4);
            data  = $urandom;
            serve(word_of(pc), waits, data, (waits > 0) && ($urandom_range(0, 4) == 0), got);
            if (got) begin
                hf = ($urandom_range(0, 4) == 0);
                ne = 1'($urandom_range(0, 1));
                np = $urandom;
                hold(data, word_of(pc), $urandom_range(0, 3), hf, ne, np);
                in_req = ne && !hf;
            end else begin
                in_req = 1'b0;
            end
        end
        if (in_req) begin
            serve(word_of(np), 0, 32'h7777_7777, 1'b0, got);
            hold(32'h7777_7777, word_of(np), 0, 1'b0, 1'b0, 32'd0);
        end

        cyc();
        cyc();
        chk("adv_count", adv_seen, adv_exp);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
